// File: rtl/silife_grid.sv
// Game-of-Life (B3/S23) engine for an 8x8 grid: host row writes in IDLE,
// row-serial next-generation computation in CALC, atomic commit to `cells`.
module silife_grid #(
  parameter int GEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [2:0]           wr_row,
  input  logic [7:0]           wr_data,
  input  logic                 step,
  input  logic                 wrap_edges,
  output logic                 busy,
  output logic                 done,
  output logic [GEN_WIDTH-1:0] generation,
  output logic [63:0]          cells
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  logic [0:0]  state;
  logic [2:0]  row_k;
  logic [63:0] cur;
  logic [63:0] nxt;
  logic        wrap_q;

  logic [2:0]  k_up;
  logic [2:0]  k_dn;
  logic [7:0]  row_up;
  logic [7:0]  row_mid;
  logic [7:0]  row_dn;
  logic [7:0]  row_new;

  // Rows are padded with one phantom column on each side, so every cell sees
  // a uniform 3x3 window whether the grid wraps or not.
  function automatic logic [7:0] next_row(input logic [7:0] up, input logic [7:0] mid,
                                          input logic [7:0] dn, input logic wrap);
    logic [9:0] ux;
    logic [9:0] mx;
    logic [9:0] dx;
    logic [3:0] cnt;
    logic [7:0] res;
    ux  = {wrap & up[0],  up,  wrap & up[7]};
    mx  = {wrap & mid[0], mid, wrap & mid[7]};
    dx  = {wrap & dn[0],  dn,  wrap & dn[7]};
    res = '0;
    for (int c = 0; c < 8; c++) begin
      cnt = 4'(ux[c]) + 4'(ux[c+1]) + 4'(ux[c+2])
          + 4'(mx[c])               + 4'(mx[c+2])
          + 4'(dx[c]) + 4'(dx[c+1]) + 4'(dx[c+2]);
      res[c] = (cnt == 4'd3) | (mx[c+1] & (cnt == 4'd2));
    end
    return res;
  endfunction

  assign k_up    = row_k - 3'd1;
  assign k_dn    = row_k + 3'd1;
  assign row_mid = cur[{row_k, 3'b000} +: 8];
  assign row_up  = (row_k == 3'd0 && !wrap_q) ? 8'h00 : cur[{k_up, 3'b000} +: 8];
  assign row_dn  = (row_k == 3'd7 && !wrap_q) ? 8'h00 : cur[{k_dn, 3'b000} +: 8];
  assign row_new = next_row(row_up, row_mid, row_dn, wrap_q);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would let row_k or cur race.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row_k      <= 3'd0;
      cur        <= '0;
      nxt        <= '0;
      wrap_q     <= 1'b0;
      done       <= 1'b0;
      generation <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            cur[{wr_row, 3'b000} +: 8] <= wr_data;
          end else if (step) begin
            state  <= CALC;
            row_k  <= 3'd0;
            wrap_q <= wrap_edges;
          end
        end
        CALC: begin
          nxt[{row_k, 3'b000} +: 8] <= row_new;
          row_k <= row_k + 3'd1;
          if (row_k == 3'd7) begin
            // Row 7 bypasses nxt so the whole new frame lands in one edge.
            cur        <= {row_new, nxt[55:0]};
            generation <= generation + 1'b1;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == CALC);
  assign cells = cur;

endmodule
